rvecc_secded_pipe: RTL

- Parametrised, pipelined SECDED decoder for streaming codewords. Successor to the combinational rvecc_decode.
- Generalised in data width. Adds a valid/ready handshake, a 2-stage pipeline, saturating error-statistics counters and a sticky first-error log.
- Sits between a memory/channel read port and the consumer.
- For DATA_W=32 it is bit-compatible with rvecc_encode/rvecc_decode (7 check bits).

---
 rtl/rvecc_secded_pipe.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rvecc_secded_pipe.sv
// rvecc_secded_pipe: two-stage pipelined SECDED decoder with valid/ready flow control,
// saturating SEC/DED counters and a sticky first-error log. RVECC_ERR_INJECT_EN adds one-shot injection.
module rvecc_secded_pipe #(
  parameter int  DATA_W = 32,
  parameter int  TAG_W  = 8,
  parameter int  CNT_W  = 16,
  localparam int R      = (DATA_W <= 4)  ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : (DATA_W <= 120) ? 7 : 8,
  localparam int ECC_W  = R + 1
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [ECC_W-1:0]        in_ecc,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [ECC_W-1:0]        out_ecc,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    out_sec,
  output logic                    out_ded,
  output logic [CNT_W-1:0]        sec_cnt,
  output logic [CNT_W-1:0]        ded_cnt,
  output logic                    log_valid,
  output logic [ECC_W-1:0]        log_syndrome,
  output logic [TAG_W-1:0]        log_tag,
  output logic                    log_ded,
`ifdef RVECC_ERR_INJECT_EN
  input  logic [DATA_W+ECC_W-1:0] inj_mask,
  input  logic                    inj_arm,
`endif
  input  logic                    cnt_clr,
  input  logic                    log_clr
);

  localparam int N = DATA_W + R;

  // Hamming position of data bit idx: the idx-th position in 1..N that is not a power of two.
  function automatic int data_pos(input int idx);
    int c;
    int p;
    c = 0;
    p = 0;
    for (int q = 1; q <= N; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (c == idx) p = q;
        c++;
      end
    end
    return p;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic              vld_p1, vld_p2;
  logic              s2_free, xfer_in, adv_p2, xfer_out;
  logic [DATA_W-1:0] data_p0, data_p1, data_p2, fix_data;
  logic [ECC_W-1:0]  ecc_p0, ecc_p1, ecc_p2, fix_ecc;
  logic [TAG_W-1:0]  tag_p1, tag_p2;
  logic [R-1:0]      syn_p0, syn_p1;
  logic [ECC_W-1:0]  syn_p2;
  logic              par_p0, par_p1;
  logic              sec_c, ded_c, sec_p2, ded_p2;

  assign s2_free  = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || s2_free;
  assign xfer_in  = in_valid && in_ready;
  assign adv_p2   = vld_p1 && s2_free;
  assign xfer_out = vld_p2 && out_ready;

`ifdef RVECC_ERR_INJECT_EN
  logic inj_used;
  logic inj_live;
  assign inj_live = inj_arm && !inj_used;
  assign {ecc_p0, data_p0} = {in_ecc, in_data} ^ (inj_live ? inj_mask : '0);

  // Disarms after one accepted word; re-arms only once inj_arm has been seen low.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)        inj_used <= 1'b0;
    else if (!inj_arm) inj_used <= 1'b0;
    else if (xfer_in)  inj_used <= 1'b1;
  end
`else
  assign data_p0 = in_data;
  assign ecc_p0  = in_ecc;
`endif

  // ---- stage 0 -> 1: syndrome and overall parity of the received word
  always_comb begin
    syn_p0 = ecc_p0[R-1:0];
    for (int i = 0; i < DATA_W; i++)
      if (data_p0[i]) syn_p0 = syn_p0 ^ R'(data_pos(i));
    par_p0 = ^{ecc_p0, data_p0};
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready) vld_p1 <= in_valid;
      if (s2_free)  vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer_in) begin
      data_p1 <= data_p0;
      ecc_p1  <= ecc_p0;
      tag_p1  <= in_tag;
      syn_p1  <= syn_p0;
      par_p1  <= par_p0;
    end
  end

  // ---- stage 1 -> 2: correction; DED and out-of-range syndromes leave the word untouched
  always_comb begin
    fix_data = data_p1;
    fix_ecc  = ecc_p1;
    sec_c    = 1'b0;
    ded_c    = 1'b0;
    if (par_p1) begin
      if (syn_p1 == '0) begin
        fix_ecc[R] = ~ecc_p1[R];
        sec_c      = 1'b1;
      end else if (int'(syn_p1) > N) begin
        ded_c = 1'b1;
      end else begin
        sec_c = 1'b1;
        for (int k = 0; k < R; k++)
          if (int'(syn_p1) == (1 << k)) fix_ecc[k] = ~ecc_p1[k];
        for (int i = 0; i < DATA_W; i++)
          if (int'(syn_p1) == data_pos(i)) fix_data[i] = ~data_p1[i];
      end
    end else if (syn_p1 != '0) begin
      ded_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_p2) begin
      data_p2 <= fix_data;
      ecc_p2  <= fix_ecc;
      tag_p2  <= tag_p1;
      sec_p2  <= sec_c;
      ded_p2  <= ded_c;
      syn_p2  <= {par_p1, syn_p1};
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = vld_p2 ? data_p2 : '0;
  assign out_ecc   = vld_p2 ? ecc_p2  : '0;
  assign out_tag   = vld_p2 ? tag_p2  : '0;
  assign out_sec   = vld_p2 && sec_p2;
  assign out_ded   = vld_p2 && ded_p2;

  // ---- statistics on delivered words; clear wins but still counts a same-cycle transfer
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sec_cnt      <= '0;
      ded_cnt      <= '0;
      log_valid    <= 1'b0;
      log_syndrome <= '0;
      log_tag      <= '0;
      log_ded      <= 1'b0;
    end else begin
      if (cnt_clr)                  sec_cnt <= (xfer_out && sec_p2) ? CNT_W'(1) : '0;
      else if (xfer_out && sec_p2)  sec_cnt <= sat_inc(sec_cnt);
      if (cnt_clr)                  ded_cnt <= (xfer_out && ded_p2) ? CNT_W'(1) : '0;
      else if (xfer_out && ded_p2)  ded_cnt <= sat_inc(ded_cnt);
      if (xfer_out && (sec_p2 || ded_p2) && (!log_valid || log_clr)) begin
        log_valid    <= 1'b1;
        log_syndrome <= syn_p2;
        log_tag      <= tag_p2;
        log_ded      <= ded_p2;
      end else if (log_clr) begin
        log_valid    <= 1'b0;
        log_syndrome <= '0;
        log_tag      <= '0;
        log_ded      <= 1'b0;
      end
    end
  end

endmodule
